// File: rtl/rope_constraint_solver_pkg.sv
// Shared definitions for the rope distance-constraint solver: fixed-point
// format, default rest length, saturation helper and FSM state encoding.
package rope_constraint_solver_pkg;

  localparam int          FRAC_W           = 16;
  localparam logic [31:0] REST_LEN_DEFAULT = 32'h0000_C000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DELTA,
    ST_SQUARE,
    ST_SQRT,
    ST_SCALE,
    ST_DIV,
    ST_ACC,
    ST_DONE
  } state_t;

  // Clamp a 34-bit signed intermediate into signed 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [33:0] v);
    if (v[33:31] == 3'b000 || v[33:31] == 3'b111) begin
      return v[31:0];
    end else if (v[33]) begin
      return 32'sh8000_0000;
    end else begin
      return 32'sh7fff_ffff;
    end
  endfunction

endpackage

// File: rtl/rope_constraint_solver_fx_sqrt_serial.sv
// Restoring bit-serial square root: floor(sqrt(64-bit radicand)) -> 32 bits.
// The first iteration happens on the start edge; done pulses 32 cycles later.
module fx_sqrt_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [63:0] i_radicand,
  output logic        o_done,
  output logic [31:0] o_root
);

  logic [63:0] r_rad;
  logic [33:0] r_rem;
  logic [31:0] r_root;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  logic [63:0] w_rad;
  logic [33:0] w_rem;
  logic [31:0] w_root;
  logic [35:0] w_shift;
  logic        w_ge;
  logic [33:0] w_diff;

  // A new start overrides whatever state the iteration registers hold.
  assign w_rad   = i_start ? i_radicand : r_rad;
  assign w_rem   = i_start ? 34'd0 : r_rem;
  assign w_root  = i_start ? 32'd0 : r_root;
  assign w_shift = {w_rem, w_rad[63:62]};
  assign w_ge    = w_shift >= {2'b00, w_root, 2'b01};
  assign w_diff  = w_shift[33:0] - {w_root, 2'b01};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rad  <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start || r_busy) begin
        r_rad  <= {w_rad[61:0], 2'b00};
        r_rem  <= w_ge ? w_diff : w_shift[33:0];
        r_root <= {w_root[30:0], w_ge};
        if (i_start) begin
          r_busy <= 1'b1;
          r_cnt  <= 5'd1;
        end else begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_root = r_root;

endmodule

// File: rtl/rope_constraint_solver.sv
// Distance-constraint solver for one interior rope node: two fixed-latency
// passes (upper then lower neighbour) pulling the node back on stretch only.
module rope_constraint_solver
  import rope_constraint_solver_pkg::*;
#(
  parameter logic [31:0] REST_LEN = REST_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] up_x_pos,
  input  logic [31:0] up_y_pos,
  input  logic [31:0] x_pos,
  input  logic [31:0] y_pos,
  input  logic [31:0] down_x_pos,
  input  logic [31:0] down_y_pos,
  input  logic        is_last,
  output logic        busy,
  output logic        done,
  output logic [31:0] x_enforced_constraints,
  output logic [31:0] y_enforced_constraints
);

  state_t r_state;
  state_t w_state_next;

  // Per-axis storage, index 0 = x, 1 = y.
  logic signed [31:0] r_p   [2];
  logic signed [31:0] r_up  [2];
  logic signed [31:0] r_dn  [2];
  logic signed [31:0] r_d   [2];
  logic signed [33:0] r_acc [2];
  logic signed [31:0] r_out [2];
  logic [31:0]        r_drem[2];
  logic [47:0]        r_ddvd[2];
  logic [33:0]        r_quo [2];
  logic [1:0]         r_neg;
  logic               r_pass;
  logic               r_is_last;
  logic               r_skip;
  logic [5:0]         r_cnt;
  logic               r_busy;
  logic               r_done;

  logic signed [31:0] w_in_p [2];
  logic signed [31:0] w_in_up[2];
  logic signed [31:0] w_in_dn[2];
  logic signed [31:0] w_nb   [2];
  logic signed [31:0] w_delta[2];
  logic signed [63:0] w_sq   [2];
  logic signed [63:0] w_prod [2];
  logic signed [63:0] w_sh   [2];
  logic [63:0]        w_mag  [2];
  logic [32:0]        w_dshift[2];
  logic               w_dge  [2];
  logic [31:0]        w_ddiff[2];
  logic signed [33:0] w_q    [2];
  logic signed [33:0] w_c    [2];
  logic [63:0]        w_s;
  logic [31:0]        w_root;
  logic [31:0]        w_e;
  logic signed [63:0] w_e64;
  logic               w_sqrt_done;
  logic               w_sqrt_start;

  assign w_in_p[0]  = x_pos;
  assign w_in_p[1]  = y_pos;
  assign w_in_up[0] = up_x_pos;
  assign w_in_up[1] = up_y_pos;
  assign w_in_dn[0] = down_x_pos;
  assign w_in_dn[1] = down_y_pos;

  assign w_s          = w_sq[0] + w_sq[1];
  assign w_e          = w_root - REST_LEN;
  assign w_e64        = {32'd0, w_e};
  assign w_sqrt_start = (r_state == ST_SQUARE);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      assign w_nb[gi]    = r_pass ? r_dn[gi] : r_up[gi];
      assign w_delta[gi] = sat32({{2{r_p[gi][31]}}, r_p[gi]} - {{2{w_nb[gi][31]}}, w_nb[gi]});
      assign w_sq[gi]    = 64'(r_d[gi]) * 64'(r_d[gi]);
      assign w_prod[gi]  = 64'(r_d[gi]) * w_e64;
      assign w_sh[gi]    = w_prod[gi] >>> FRAC_W;
      assign w_mag[gi]   = w_sh[gi][63] ? 64'(-w_sh[gi]) : 64'(w_sh[gi]);
      // Magnitude long division; quotient is known to fit in 33 bits.
      assign w_dshift[gi] = {r_drem[gi], r_ddvd[gi][47]};
      assign w_dge[gi]    = w_dshift[gi] >= {1'b0, w_root};
      assign w_ddiff[gi]  = w_dshift[gi][31:0] - w_root;
      assign w_q[gi]      = r_neg[gi] ? -$signed(r_quo[gi]) : $signed(r_quo[gi]);
      assign w_c[gi]      = r_skip ? 34'sd0 : (w_q[gi] >>> 1);
    end
  endgenerate

  fx_sqrt_serial u_sqrt (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_sqrt_start),
    .i_radicand(w_s),
    .o_done    (w_sqrt_done),
    .o_root    (w_root)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (start) w_state_next = ST_DELTA;
      ST_DELTA:  w_state_next = ST_SQUARE;
      ST_SQUARE: w_state_next = ST_SQRT;
      ST_SQRT:   if (w_sqrt_done) w_state_next = ST_SCALE;
      ST_SCALE:  w_state_next = ST_DIV;
      ST_DIV:    if (r_cnt == 6'd47) w_state_next = ST_ACC;
      ST_ACC:    w_state_next = r_pass ? ST_DONE : ST_DELTA;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pass    <= 1'b0;
      r_is_last <= 1'b0;
      r_skip    <= 1'b0;
      r_neg     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      for (int k = 0; k < 2; k++) begin
        r_p[k]    <= '0;
        r_up[k]   <= '0;
        r_dn[k]   <= '0;
        r_d[k]    <= '0;
        r_acc[k]  <= '0;
        r_out[k]  <= '0;
        r_drem[k] <= '0;
        r_ddvd[k] <= '0;
        r_quo[k]  <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_pass    <= 1'b0;
            r_is_last <= is_last;
            for (int k = 0; k < 2; k++) begin
              r_p[k]   <= w_in_p[k];
              r_up[k]  <= w_in_up[k];
              r_dn[k]  <= w_in_dn[k];
              r_acc[k] <= {{2{w_in_p[k][31]}}, w_in_p[k]};
            end
          end
        end
        ST_DELTA: begin
          for (int k = 0; k < 2; k++) r_d[k] <= w_delta[k];
        end
        ST_SCALE: begin
          // The down pass still runs in full when is_last, only its result is dropped.
          r_skip <= (w_root <= REST_LEN) || (w_root == 32'd0) || (r_pass && r_is_last);
          r_cnt  <= '0;
          for (int k = 0; k < 2; k++) begin
            r_neg[k]  <= w_sh[k][63];
            r_drem[k] <= w_mag[k][63:32];
            r_ddvd[k] <= {w_mag[k][31:0], 16'd0};
            r_quo[k]  <= '0;
          end
        end
        ST_DIV: begin
          r_cnt <= r_cnt + 6'd1;
          for (int k = 0; k < 2; k++) begin
            r_drem[k] <= w_dge[k] ? w_ddiff[k] : w_dshift[k][31:0];
            r_ddvd[k] <= {r_ddvd[k][46:0], 1'b0};
            r_quo[k]  <= {r_quo[k][32:0], w_dge[k]};
          end
        end
        ST_ACC: begin
          r_pass <= 1'b1;
          for (int k = 0; k < 2; k++) r_acc[k] <= r_acc[k] - w_c[k];
        end
        ST_DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
          for (int k = 0; k < 2; k++) r_out[k] <= sat32(r_acc[k]);
        end
        default: ;
      endcase
    end
  end

  assign busy                   = r_busy;
  assign done                   = r_done;
  assign x_enforced_constraints = r_out[0];
  assign y_enforced_constraints = r_out[1];

endmodule

// File: tb/tb_rope_constraint_solver.sv
// Directed-vector bench for rope_constraint_solver: hand-computed results,
// fixed latency, output hold, ignored start while busy and mid-run reset.
module tb_rope_constraint_solver;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] up_x_pos, up_y_pos, x_pos, y_pos, down_x_pos, down_y_pos;
  logic        is_last;
  logic        busy, done;
  logic [31:0] x_enforced_constraints, y_enforced_constraints;

  always #5 clk = ~clk;

  rope_constraint_solver dut (
    .clk                   (clk),
    .rst                   (rst),
    .start                 (start),
    .up_x_pos              (up_x_pos),
    .up_y_pos              (up_y_pos),
    .x_pos                 (x_pos),
    .y_pos                 (y_pos),
    .down_x_pos            (down_x_pos),
    .down_y_pos            (down_y_pos),
    .is_last               (is_last),
    .busy                  (busy),
    .done                  (done),
    .x_enforced_constraints(x_enforced_constraints),
    .y_enforced_constraints(y_enforced_constraints)
  );

  typedef struct {
    logic [31:0] ux, uy, px, py, nx, ny;
    logic        last;
    logic [31:0] ex, ey;
  } vec_t;

  localparam int NVEC = 9;
  localparam int LAT  = 169;

  vec_t        vecs[NVEC];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] prev_x = '0;
  logic [31:0] prev_y = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  task automatic apply(input vec_t v);
    up_x_pos   = v.ux;
    up_y_pos   = v.uy;
    x_pos      = v.px;
    y_pos      = v.py;
    down_x_pos = v.nx;
    down_y_pos = v.ny;
    is_last    = v.last;
  endtask

  task automatic scramble();
    up_x_pos   = 32'h1234_5678;
    up_y_pos   = 32'h8765_4321;
    x_pos      = 32'hdead_beef;
    y_pos      = 32'h0bad_f00d;
    down_x_pos = 32'h5555_aaaa;
    down_y_pos = 32'haaaa_5555;
    is_last    = ~is_last;
  endtask

  task automatic run_vec(input int i, input bit inject);
    int   lat;
    vec_t v;
    v   = vecs[i];
    lat = 0;
    @(posedge clk); #1;
    apply(v);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble();
    chk($sformatf("v%0d busy_after_start", i), {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (inject && k == 20) start = 1'b1;
      if (inject && k == 21) start = 1'b0;
      if (k == 100) begin
        chk($sformatf("v%0d x_hold", i), x_enforced_constraints, prev_x);
        chk($sformatf("v%0d y_hold", i), y_enforced_constraints, prev_y);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("v%0d edges_to_done", i), lat, LAT);
    chk($sformatf("v%0d busy_at_done", i), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d x", i), x_enforced_constraints, v.ex);
    chk($sformatf("v%0d y", i), y_enforced_constraints, v.ey);
    $display("vec %0d: x=0x%08h y=0x%08h edges=%0d", i, x_enforced_constraints,
             y_enforced_constraints, lat);
    prev_x = v.ex;
    prev_y = v.ey;
  endtask

  initial begin
    int extra;
    vecs[0] = '{32'h000c9b36, 32'h000aae67, 32'h000c9b36, 32'h000b4e67, 32'h000c9b36, 32'h000c3e67,
                1'b0, 32'h000c9b36, 32'h000b6667};
    vecs[1] = '{32'h000c9b36, 32'h000aae67, 32'h000c9b36, 32'h000b4e67, 32'h000c9b36, 32'h000c3e67,
                1'b1, 32'h000c9b36, 32'h000b4e67};
    vecs[2] = '{32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000, 32'h00010000,
                1'b0, 32'h00010000, 32'h00010000};
    vecs[3] = '{32'h00000000, 32'h00000000, 32'h00030000, 32'h00040000, 32'h00030000, 32'h00040000,
                1'b0, 32'h0001b99a, 32'h00024ccd};
    vecs[4] = '{32'h00000000, 32'h00000000, 32'hfffd0000, 32'hfffc0000, 32'hfffd0000, 32'hfffc0000,
                1'b0, 32'hfffe4666, 32'hfffdb333};
    vecs[5] = '{32'hfffe0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
                1'b0, 32'hffff6000, 32'h00000000};
    vecs[6] = '{32'h00000000, 32'hfffe0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00010000,
                1'b0, 32'h00000000, 32'hffff8000};
    vecs[7] = '{32'h00000000, 32'hfffe0000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h00010000,
                1'b1, 32'h00000000, 32'hffff6000};
    vecs[8] = '{32'h80000000, 32'h00000000, 32'h7fff0000, 32'h00000000, 32'h7fff0000, 32'h00000000,
                1'b0, 32'h3fff6001, 32'h00000000};

    rst   = 1'b1;
    start = 1'b0;
    apply('{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0});
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset x", x_enforced_constraints, 32'd0);
    chk("reset y", y_enforced_constraints, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) run_vec(i, i == NVEC - 1);

    // A start issued while busy must not produce a second result.
    extra = 0;
    for (int k = 0; k < 250; k++) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    chk("ignored_start extra_done", extra, 0);

    // Reset in the middle of a computation clears everything immediately.
    @(posedge clk); #1;
    apply(vecs[3]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset x", x_enforced_constraints, 32'd0);
    chk("midreset y", y_enforced_constraints, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst    = 1'b0;
    prev_x = '0;
    prev_y = '0;
    run_vec(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
